// File: rtl/iir_bank_accum.sv
// Serial float accumulator: sums the enabled outputs of N_SEC IIR sections into one result,
// one section per cycle through a single shared float adder, with valid/ready on both sides.
module iir_bank_accum #(
  parameter int unsigned MAN   = 23,
  parameter int unsigned EXP   = 8,
  parameter int unsigned N_SEC = 6,
  parameter int unsigned IW    = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_SEC*(MAN+EXP+1)-1:0]   sec_float,
  input  logic [N_SEC-1:0]               sec_mask,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MAN+EXP:0]               y_float,
  output logic                           busy
);

  localparam int unsigned W  = MAN + EXP + 1;
  localparam int unsigned MW = MAN + 4;  // hidden bit + mantissa + guard/round/sticky

  // Float add, round-to-nearest-even; denormal inputs are treated as zero, overflow gives Inf.
  function automatic logic [W-1:0] soma(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]    x, y;
    logic [EXP-1:0]  ex, ey;
    logic [MW-1:0]   mx, my, sh;
    logic [MW:0]     s;
    logic [MAN+1:0]  t;
    logic [MAN-1:0]  man;
    logic            sg, rnd;
    int              e, d;
    if (a[W-2:0] >= b[W-2:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = x[W-2:MAN];
    ey = y[W-2:MAN];
    if (ey == '0) return (ex == '0) ? '0 : x;
    mx = {1'b1, x[MAN-1:0], 3'b000};
    my = {1'b1, y[MAN-1:0], 3'b000};
    d  = int'(ex) - int'(ey);
    if (d >= int'(MW)) begin
      sh = {{(MW-1){1'b0}}, 1'b1};
    end else begin
      sh    = my >> d;
      sh[0] = sh[0] | (|(my & ~({MW{1'b1}} << d)));
    end
    e  = int'(ex);
    sg = x[W-1];
    if (x[W-1] == y[W-1]) s = {1'b0, mx} + {1'b0, sh};
    else                  s = {1'b0, mx} - {1'b0, sh};
    if (s == '0) return '0;
    if (s[MW]) begin
      s = {1'b0, s[MW:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < int'(MW); i++) begin
        if (!s[MW-1]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    t   = {1'b0, s[MW-1:3]} + (MAN+2)'(rnd);
    if (t[MAN+1]) begin
      e   = e + 1;
      man = '0;
    end else begin
      man = t[MAN-1:0];
    end
    if (e >= (1 << EXP) - 1) return {sg, {EXP{1'b1}}, {MAN{1'b0}}};
    if (e <= 0) return '0;
    return {sg, EXP'(e), man};
  endfunction

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e               state_q;
  logic [IW-1:0]        idx_q;
  logic [W-1:0]         acc_q, y_q;
  logic [N_SEC*W-1:0]   sec_q;
  logic [N_SEC-1:0]     mask_q;
  logic [W-1:0]         sec_cur, sum, acc_d;

  always_comb begin
    sec_cur = sec_q[int'(idx_q)*W +: W];
    sum     = soma(acc_q, sec_cur);
    acc_d   = mask_q[idx_q] ? sum : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      sec_q   <= '0;
      mask_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sec_q   <= sec_float;
            mask_q  <= sec_mask;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= acc_d;
          if (idx_q == IW'(N_SEC - 1)) begin
            y_q     <= acc_d;
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign y_float   = y_q;

endmodule
